shutter_scheduler: RTL and testbench
====================================

Name: shutter_scheduler

Overview:
Controller that owns the `direct` input of the shutter motor controller and shares it between two requesters: a manual push-button path and an automatic light-sensor path.
- Captures requests and arbitrates with manual priority.
- Toggles `direct` and holds off further commands until the motor cycle and a settling dwell have elapsed.
- Locks out automatic requests for a period after any manual move.
- Sits between the user/sensor logic and the motor controller, in the `clk_50` domain.

Parameters:
CLK_PER_MS, 50000, clk_50 cycles per millisecond tick (16-bit prescaler, must be >= 2)
MOVE_MS, 6, ms to hold after a direction change; must exceed the motor controller's 4 ms drive window
DWELL_MS, 20, ms of settling lockout after MOVE before the next grant
OVERRIDE_MS, 5000, ms that auto requests are held off after a manual move completes (16-bit)

Ports:
clk_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-low reset (low = reset)
man_req  in  1  manual request; rising edge captured
man_dir  in  1  manual target direction (1 = up, 0 = down), sampled with the man_req rising edge
auto_req  in  1  automatic request; rising edge captured
auto_dir  in  1  automatic target direction, sampled with the auto_req rising edge
auto_en  in  1  enables the automatic path; low drops any pending auto request
direct  out  1  direction command to the motor controller
busy  out  1  high during MOVE and DWELL
grant_src  out  1  1 = manual, 0 = auto; source of the current/last grant
man_ack  out  1  one-cycle pulse when a manual request is retired
auto_ack  out  1  one-cycle pulse when an auto request is retired
override_active  out  1  high while the auto lockout counter is non-zero

Behaviour:
- Everything is synchronous to posedge clk_50. While reset = 0, all state is loaded at the clock edge:
  - state = IDLE
  - direct = 0, busy = 0, grant_src = 0, man_ack = 0, auto_ack = 0, override_active = 0
  - pending flags cleared, counters cleared, edge-detect history regs cleared
- Capture:
  - A registered edge detect sets man_pend and latches man_pdir on a man_req 0->1 transition (same for auto).
  - A new edge while a request is already pending overwrites the latched direction; the latest edge wins.
  - A capture in the same cycle as that source's retire leaves pend = 1 with the new direction.
- Auto gating: auto_en = 0 clears auto_pend every cycle and blocks capture. No ack is issued for a dropped request.
- Prescaler:
  - Counts 0..CLK_PER_MS-1 and emits ms_tick on wrap.
  - Cleared on entry to MOVE and on entry to DWELL; otherwise free-running.
- FSM states are IDLE, MOVE and DWELL.
- IDLE grant selection:
  - If man_pend, grant manual.
  - Else if auto_pend and override counter == 0, grant auto.
  - Else stay in IDLE.
- IDLE on a grant: set grant_src and clear the selected pend flag.
  - If the latched direction == direct: no-op. The ack pulses in the next cycle, the state stays IDLE, busy stays 0, and the override counter is not reloaded.
  - Else: direct <= latched direction, busy <= 1, ms_cnt <= 0, go to MOVE.
- MOVE: ms_cnt increments on ms_tick. On reaching MOVE_MS, go to DWELL and clear ms_cnt. Duration is exactly MOVE_MS*CLK_PER_MS cycles.
- DWELL: same counting, against DWELL_MS. On exit:
  - go to IDLE and busy <= 0;
  - the ack for grant_src pulses in the same cycle busy falls;
  - if grant_src = 1, the override counter is loaded with OVERRIDE_MS.
- Direction latency: direct changes one cycle after the IDLE grant. Ack latency is MOVE_MS*CLK_PER_MS + DWELL_MS*CLK_PER_MS cycles after direct changes.
- Override counter:
  - Decrements on ms_tick when non-zero and saturates at 0.
  - override_active = (counter != 0), registered.
  - While it is non-zero, auto requests stay pending; they are not dropped.
- Requests arriving during MOVE/DWELL are captured and served in IDLE afterwards, at most one grant per IDLE cycle.
- man_ack and auto_ack are never high in the same cycle, and neither lasts longer than one cycle.
- Reset asserted mid-MOVE/DWELL: abort immediately. direct returns to 0, no ack is issued, and pending requests are lost.

Test Plan:
Bench parameters: CLK_PER_MS=10, MOVE_MS=3, DWELL_MS=2, OVERRIDE_MS=4.
1. Reset held 3 cycles, then released with no requests -> all outputs 0 for 100 cycles.
2. Single-cycle man_req with man_dir=1 from IDLE, direct=0:
   - direct=1 and busy=1 two cycles after the edge;
   - busy stays high exactly 50 cycles;
   - man_ack=1 for 1 cycle as busy falls; grant_src=1; override_active=1.
3. With direct=1, auto_en=1, auto_req edge with auto_dir=1 (override expired) -> auto_ack pulse 2 cycles after the edge; busy never rises; direct stays 1.
4. man_req (dir=0) and auto_req (dir=1) rise in the same cycle, direct=1:
   - manual served first: direct=0, man_ack after 50 cycles;
   - auto is then held 40 cycles (override_active=1); direct=1 follows 1 cycle after override_active falls;
   - auto_ack follows 50 cycles after that.
5. auto_req edge captured during a manual MOVE, then auto_en driven 0 for 1 cycle before DWELL ends -> no auto grant, no auto_ack, direct unchanged after man_ack.
6. Reset pulsed low 1 cycle mid-MOVE with direct=1 and a manual request pending -> next cycle direct=0, busy=0, no ack, and the pending request is not served after release.

Source files
------------

// File: rtl/shutter_scheduler.sv
// shutter_scheduler: shares the motor controller's direction input between a
// manual push-button requester and an automatic light-sensor requester.
// Manual requests win arbitration. Every direction change is followed by a
// MOVE hold and a DWELL settling period. A manual move also holds off auto
// requests for OVERRIDE_MS.
module shutter_scheduler #(
  parameter int unsigned CLK_PER_MS  = 50000,
  parameter int unsigned MOVE_MS     = 6,
  parameter int unsigned DWELL_MS    = 20,
  parameter int unsigned OVERRIDE_MS = 5000
) (
  input  logic clk_50,
  input  logic reset,
  input  logic man_req,
  input  logic man_dir,
  input  logic auto_req,
  input  logic auto_dir,
  input  logic auto_en,
  output logic direct,
  output logic busy,
  output logic grant_src,
  output logic man_ack,
  output logic auto_ack,
  output logic override_active
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_man_req_d;
  logic            r_auto_req_d;
  logic            r_man_pend;
  logic            r_man_pdir;
  logic            r_auto_pend;
  logic            r_auto_pdir;
  logic [CW-1:0]   r_pre;
  logic [CW-1:0]   r_ms_cnt;
  logic [CW-1:0]   r_ovr;
  logic            r_direct;
  logic            r_busy;
  logic            r_grant_src;
  logic            r_man_ack;
  logic            r_auto_ack;
  logic            r_ovr_active;

  logic            w_man_edge;
  logic            w_auto_edge;
  logic            w_tick;
  logic            w_idle_free;
  logic            w_grant_man;
  logic            w_grant_auto;
  logic            w_gdir;
  logic            w_start_move;
  logic            w_move_done;
  logic            w_dwell_done;
  logic [CW-1:0]   w_ovr_next;

  assign w_man_edge   = man_req & ~r_man_req_d;
  assign w_auto_edge  = auto_req & ~r_auto_req_d & auto_en;
  assign w_tick       = (r_pre == CW'(CLK_PER_MS - 1));

  // No grant while an ack is showing, so consecutive retires of the same
  // source never merge into a pulse longer than one cycle.
  assign w_idle_free  = (r_state == ST_IDLE) & ~r_man_ack & ~r_auto_ack;
  assign w_grant_man  = w_idle_free & r_man_pend;
  assign w_grant_auto = w_idle_free & ~r_man_pend & r_auto_pend & auto_en &
                        (r_ovr == '0);
  assign w_gdir       = w_grant_man ? r_man_pdir : r_auto_pdir;
  assign w_start_move = (w_grant_man | w_grant_auto) & (w_gdir != r_direct);
  assign w_move_done  = (r_state == ST_MOVE) & w_tick &
                        (r_ms_cnt == CW'(MOVE_MS - 1));
  assign w_dwell_done = (r_state == ST_DWELL) & w_tick &
                        (r_ms_cnt == CW'(DWELL_MS - 1));

  // Next override count: reload after a manual move, else count down to 0.
  always_comb begin
    w_ovr_next = r_ovr;
    if (w_dwell_done && r_grant_src) begin
      w_ovr_next = CW'(OVERRIDE_MS);
    end else if (w_tick && (r_ovr != '0)) begin
      w_ovr_next = r_ovr - CW'(1);
    end
  end

  // Edge history and request capture; the latest edge wins the direction.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      r_man_req_d  <= 1'b0;
      r_auto_req_d <= 1'b0;
      r_man_pend   <= 1'b0;
      r_man_pdir   <= 1'b0;
      r_auto_pend  <= 1'b0;
      r_auto_pdir  <= 1'b0;
    end else begin
      r_man_req_d  <= man_req;
      r_auto_req_d <= auto_req;
      if (w_man_edge) begin
        r_man_pend <= 1'b1;
        r_man_pdir <= man_dir;
      end else if (w_grant_man) begin
        r_man_pend <= 1'b0;
      end
      if (!auto_en) begin
        r_auto_pend <= 1'b0;
      end else if (w_auto_edge) begin
        r_auto_pend <= 1'b1;
        r_auto_pdir <= auto_dir;
      end else if (w_grant_auto) begin
        r_auto_pend <= 1'b0;
      end
    end
  end

  // Millisecond prescaler, realigned at MOVE and DWELL entry.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (w_start_move || w_move_done || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + CW'(1);
    end
  end

  // Auto lockout counter and its status flag.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      r_ovr        <= '0;
      r_ovr_active <= 1'b0;
    end else begin
      r_ovr        <= w_ovr_next;
      r_ovr_active <= (w_ovr_next != '0);
    end
  end

  // Grant/MOVE/DWELL sequencer with registered outputs.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ms_cnt    <= '0;
      r_direct    <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_src <= 1'b0;
      r_man_ack   <= 1'b0;
      r_auto_ack  <= 1'b0;
    end else begin
      r_man_ack  <= 1'b0;
      r_auto_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_man || w_grant_auto) begin
            r_grant_src <= w_grant_man;
            if (w_start_move) begin
              r_direct <= w_gdir;
              r_busy   <= 1'b1;
              r_ms_cnt <= '0;
              r_state  <= ST_MOVE;
            end else begin
              r_man_ack  <= w_grant_man;
              r_auto_ack <= w_grant_auto;
            end
          end
        end
        ST_MOVE: begin
          if (w_move_done) begin
            r_ms_cnt <= '0;
            r_state  <= ST_DWELL;
          end else if (w_tick) begin
            r_ms_cnt <= r_ms_cnt + CW'(1);
          end
        end
        ST_DWELL: begin
          if (w_dwell_done) begin
            r_ms_cnt   <= '0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
            r_man_ack  <= r_grant_src;
            r_auto_ack <= ~r_grant_src;
          end else if (w_tick) begin
            r_ms_cnt <= r_ms_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign direct          = r_direct;
  assign busy            = r_busy;
  assign grant_src       = r_grant_src;
  assign man_ack         = r_man_ack;
  assign auto_ack        = r_auto_ack;
  assign override_active = r_ovr_active;

endmodule

// File: tb/tb_shutter_scheduler.sv
// Scoreboard bench for shutter_scheduler with small timing parameters.
// Expected acks are queued when stimulus is issued; a monitor retires them.
module tb_shutter_scheduler;

  localparam int unsigned CLK_PER_MS  = 10;
  localparam int unsigned MOVE_MS     = 3;
  localparam int unsigned DWELL_MS    = 2;
  localparam int unsigned OVERRIDE_MS = 4;

  logic clk_50 = 1'b0;
  logic reset = 1'b0;
  logic man_req = 1'b0, man_dir = 1'b0;
  logic auto_req = 1'b0, auto_dir = 1'b0, auto_en = 1'b0;
  logic direct, busy, grant_src, man_ack, auto_ack, override_active;

  typedef struct {
    logic        src;
    int unsigned cyc;
    logic        dir;
    logic        ovr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  shutter_scheduler #(
    .CLK_PER_MS (CLK_PER_MS),
    .MOVE_MS    (MOVE_MS),
    .DWELL_MS   (DWELL_MS),
    .OVERRIDE_MS(OVERRIDE_MS)
  ) dut (
    .clk_50         (clk_50),
    .reset          (reset),
    .man_req        (man_req),
    .man_dir        (man_dir),
    .auto_req       (auto_req),
    .auto_dir       (auto_dir),
    .auto_en        (auto_en),
    .direct         (direct),
    .busy           (busy),
    .grant_src      (grant_src),
    .man_ack        (man_ack),
    .auto_ack       (auto_ack),
    .override_active(override_active)
  );

  always #5 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic goto_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk_50);
  endtask

  // Monitor: retires queued expectations whenever an ack pulse appears.
  always @(negedge clk_50) begin
    exp_t e;
    if (man_ack && auto_ack) chk("ack_exclusive", 1, 0);
    if (man_ack || auto_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_src", int'(man_ack), int'(e.src));
        chk("ack_cycle", int'(cyc), int'(e.cyc));
        chk("ack_direct", int'(direct), int'(e.dir));
        chk("ack_grant_src", int'(grant_src), int'(e.src));
        chk("ack_override", int'(override_active), int'(e.ovr));
        chk("ack_busy", int'(busy), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int cnt;

    // 1: reset held 3 cycles, then quiet
    repeat (3) @(negedge clk_50);
    chk("rst_direct", int'(direct), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(override_active), 0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50);
      chk("quiet_outputs",
          int'({direct, busy, grant_src, man_ack, auto_ack, override_active}), 0);
    end

    // 2: manual up from direct=0
    n = cyc;
    man_dir = 1'b1; man_req = 1'b1;
    exp_q.push_back('{src: 1'b1, cyc: n + 52, dir: 1'b1, ovr: 1'b1});
    @(negedge clk_50);
    man_req = 1'b0;
    chk("t2_direct_n1", int'(direct), 0);
    chk("t2_busy_n1", int'(busy), 0);
    @(negedge clk_50);
    chk("t2_direct_n2", int'(direct), 1);
    chk("t2_busy_n2", int'(busy), 1);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk_50);
    end
    chk("t2_busy_len", cnt, 50);
    chk("t2_grant_src", int'(grant_src), 1);
    chk("t2_override", int'(override_active), 1);
    cnt = 0;
    while (override_active && cnt < 200) begin
      cnt++;
      @(negedge clk_50);
    end
    chk("t2_override_len", cnt, 40);

    // 3: auto no-op request with same direction
    auto_en = 1'b1;
    n = cyc;
    auto_dir = 1'b1; auto_req = 1'b1;
    exp_q.push_back('{src: 1'b0, cyc: n + 2, dir: 1'b1, ovr: 1'b0});
    @(negedge clk_50);
    auto_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_busy", int'(busy), 0);
      chk("t3_direct", int'(direct), 1);
      @(negedge clk_50);
    end

    // 4: simultaneous manual (down) and auto (up) requests
    n = cyc;
    man_dir = 1'b0; man_req = 1'b1;
    auto_dir = 1'b1; auto_req = 1'b1;
    exp_q.push_back('{src: 1'b1, cyc: n + 52, dir: 1'b0, ovr: 1'b1});
    exp_q.push_back('{src: 1'b0, cyc: n + 143, dir: 1'b1, ovr: 1'b0});
    @(negedge clk_50);
    man_req = 1'b0; auto_req = 1'b0;
    @(negedge clk_50);
    chk("t4_direct_man", int'(direct), 0);
    goto_cyc(n + 91);
    chk("t4_ovr_held", int'(override_active), 1);
    chk("t4_direct_held", int'(direct), 0);
    @(negedge clk_50);
    chk("t4_ovr_fall", int'(override_active), 0);
    chk("t4_direct_still", int'(direct), 0);
    @(negedge clk_50);
    chk("t4_direct_auto", int'(direct), 1);
    chk("t4_busy_auto", int'(busy), 1);
    goto_cyc(n + 145);

    // 5: auto captured during manual move, then dropped by auto_en
    n = cyc;
    man_dir = 1'b0; man_req = 1'b1;
    exp_q.push_back('{src: 1'b1, cyc: n + 52, dir: 1'b0, ovr: 1'b1});
    @(negedge clk_50);
    man_req = 1'b0;
    goto_cyc(n + 10);
    auto_dir = 1'b1; auto_req = 1'b1;
    @(negedge clk_50);
    auto_req = 1'b0;
    goto_cyc(n + 45);
    auto_en = 1'b0;
    @(negedge clk_50);
    auto_en = 1'b1;
    goto_cyc(n + 100);
    chk("t5_direct", int'(direct), 0);
    chk("t5_busy", int'(busy), 0);
    goto_cyc(n + 120);
    chk("t5_direct_late", int'(direct), 0);

    // 6: reset pulse mid-MOVE with a manual request pending
    n = cyc;
    man_dir = 1'b1; man_req = 1'b1;
    @(negedge clk_50);
    man_req = 1'b0;
    goto_cyc(n + 5);
    man_dir = 1'b0; man_req = 1'b1;
    @(negedge clk_50);
    man_req = 1'b0;
    goto_cyc(n + 10);
    chk("t6_direct_pre", int'(direct), 1);
    chk("t6_busy_pre", int'(busy), 1);
    reset = 1'b0;
    @(negedge clk_50);
    reset = 1'b1;
    chk("t6_direct_rst", int'(direct), 0);
    chk("t6_busy_rst", int'(busy), 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_50);
      chk("t6_quiet", int'({direct, busy, man_ack, auto_ack}), 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
